// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder
//   Sequential inverse of the N-bit rotator. It is given an original word, a
//   rotated copy of it and the rotation direction. It then finds the smallest
//   rotate amount that maps the original onto the rotated word. The search
//   tries one rotation position per clock cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous, active-low reset
//   start        search request, sampled only while idle
//   a            original word, captured when a request is accepted
//   shifted      rotated word to match, captured when a request is accepted
//   direction    1 = a was rotated left, 0 = rotated right, captured on accept
//   busy         high while the search is running
//   done         one-cycle pulse when the result is valid
//   found        1 = a matching amount exists; held until the next accept
//   shiftamount  smallest matching amount, 0 when nothing matched; held
//
// N must be at least 2.
module rotate_amount_finder #(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  shifted,
  input  logic          direction,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [AW-1:0] shiftamount
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Last candidate position. When this position fails, the search has
  // exhausted every distinct rotation.
  localparam logic [AW-1:0] K_MAX = AW'(N - 1);

  logic [1:0]    state_reg;
  logic [N-1:0]  candidate_reg;
  logic [N-1:0]  target_reg;
  logic          dir_reg;
  logic [AW-1:0] k_reg;
  logic          found_reg;
  logic [AW-1:0] amount_reg;

  logic [N-1:0]  rot_left;
  logic [N-1:0]  rot_right;
  logic [N-1:0]  candidate_next;

  // Single-bit rotations of the candidate.
  // Left rotation:  bit i takes bit i-1, and bit 0 takes bit N-1.
  // Right rotation: bit i takes bit i+1, and bit N-1 takes bit 0.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi = gi + 1) begin : g_rot
      assign rot_left[gi]  = candidate_reg[(gi + N - 1) % N];
      assign rot_right[gi] = candidate_reg[(gi + 1) % N];
    end
  endgenerate

  assign candidate_next = dir_reg ? rot_left : rot_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      candidate_reg <= '0;
      target_reg    <= '0;
      dir_reg       <= 1'b0;
      k_reg         <= '0;
      found_reg     <= 1'b0;
      amount_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            candidate_reg <= a;
            target_reg    <= shifted;
            dir_reg       <= direction;
            k_reg         <= '0;
            found_reg     <= 1'b0;
            amount_reg    <= '0;
            state_reg     <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          // Test before rotating, so the first hit in counter order wins.
          // This reports the smallest amount for periodic words.
          if (candidate_reg == target_reg) begin
            amount_reg <= k_reg;
            found_reg  <= 1'b1;
            state_reg  <= ST_DONE;
          end else if (k_reg == K_MAX) begin
            amount_reg <= '0;
            found_reg  <= 1'b0;
            state_reg  <= ST_DONE;
          end else begin
            candidate_reg <= candidate_next;
            k_reg         <= k_reg + AW'(1);
          end
        end
        ST_DONE: begin
          // Any start seen in this cycle is dropped; it is not queued.
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded straight from the state register.
  // A reset therefore clears them at once, without waiting for a clock edge.
  assign busy        = (state_reg == ST_SEARCH);
  assign done        = (state_reg == ST_DONE);
  assign found       = found_reg;
  assign shiftamount = amount_reg;

endmodule

// File: tb/tb_rotate_amount_finder.sv
// Self-checking bench for rotate_amount_finder (N=8) with directed vectors.
module tb_rotate_amount_finder;

  localparam int N  = 8;
  localparam int AW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  a;
  logic [N-1:0]  shifted;
  logic          direction;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] shiftamount;

  int vec_count;
  int miscompare_count;

  rotate_amount_finder #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .shifted     (shifted),
    .direction   (direction),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .shiftamount (shiftamount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count = vec_count + 1;
    if (obs !== exp) begin
      miscompare_count = miscompare_count + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one request and checks its latency, busy length, result and hold.
  // exp_lat is the number of edges after the accepting edge until done.
  task automatic run_search(input string name, input logic [N-1:0] a_v, input logic [N-1:0] s_v,
                            input logic dir_v, input logic exp_found, input logic [AW-1:0] exp_amt,
                            input int exp_lat);
    int  cycles;
    int  busy_n;
    bit  seen;
    start     = 1'b1;
    a         = a_v;
    shifted   = s_v;
    direction = dir_v;
    step();                                     // edge 0: accept
    start     = 1'b0;
    a         = N'($urandom);                   // only captured copies may be used
    shifted   = N'($urandom);
    direction = ~dir_v;
    check_eq({name, " busy_after_accept"}, 32'(busy), 32'd1);
    busy_n = 1;
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      if (!seen) begin
        step();
        cycles = cycles + 1;
        if (done) seen = 1'b1;
        else if (busy) busy_n = busy_n + 1;
      end
    end
    check_eq({name, " done_seen"}, 32'(seen), 32'd1);
    check_eq({name, " latency"}, 32'(cycles), 32'(exp_lat));
    check_eq({name, " busy_cycles"}, 32'(busy_n), 32'(exp_lat));
    check_eq({name, " found"}, 32'(found), 32'(exp_found));
    check_eq({name, " amount"}, 32'(shiftamount), 32'(exp_amt));
    step();
    check_eq({name, " done_pulse_end"}, 32'(done), 32'd0);
    check_eq({name, " idle_busy"}, 32'(busy), 32'd0);
    step();
    check_eq({name, " found_hold"}, 32'(found), 32'(exp_found));
    check_eq({name, " amount_hold"}, 32'(shiftamount), 32'(exp_amt));
    $display("txn %s: a=%02h shifted=%02h dir=%0d -> found=%0d amount=%0d after %0d cycles",
             name, a_v, s_v, dir_v, found, shiftamount, cycles);
  endtask

  initial begin
    int cycles;
    bit seen;
    vec_count        = 0;
    miscompare_count = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    shifted   = '0;
    direction = 1'b0;

    // Reset state
    step();
    step();
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset found", 32'(found), 32'd0);
    check_eq("reset amount", 32'(shiftamount), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    check_eq("idle busy", 32'(busy), 32'd0);

    // Directed vectors
    run_search("b4_a5_left",  8'hB4, 8'hA5, 1'b1, 1'b1, 3'd3, 4);
    run_search("b4_2d_right", 8'hB4, 8'h2D, 1'b0, 1'b1, 3'd2, 3);
    run_search("b4_2d_left",  8'hB4, 8'h2D, 1'b1, 1'b1, 3'd6, 7);
    run_search("nomatch",     8'h01, 8'h03, 1'b1, 1'b0, 3'd0, 8);
    run_search("periodic",    8'h55, 8'hAA, 1'b1, 1'b1, 3'd1, 2);
    run_search("zero",        8'h00, 8'h00, 1'b0, 1'b1, 3'd0, 1);
    run_search("last_pos",    8'h01, 8'h80, 1'b0, 1'b1, 3'd1, 2);

    // Start while busy: a second request at edge 3 must be ignored.
    start = 1'b1; a = 8'h01; shifted = 8'h80; direction = 1'b1;
    step();                                     // edge 0
    start = 1'b0;
    step();                                     // edge 1
    step();                                     // edge 2
    start = 1'b1; a = 8'hB4; shifted = 8'hB4; direction = 1'b0;
    step();                                     // edge 3: ignored
    start = 1'b0;
    check_eq("busy_start busy", 32'(busy), 32'd1);
    cycles = 3;
    seen   = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      if (!seen) begin
        step();
        cycles = cycles + 1;
        if (done) seen = 1'b1;
      end
    end
    check_eq("busy_start latency", 32'(cycles), 32'd8);
    check_eq("busy_start found", 32'(found), 32'd1);
    check_eq("busy_start amount", 32'(shiftamount), 32'd7);
    $display("txn busy_start: a=01 shifted=80 dir=1 -> found=%0d amount=%0d after %0d cycles",
             found, shiftamount, cycles);
    step();
    step();

    // Start held through DONE: it is ignored in DONE and accepted in the next IDLE.
    start = 1'b1; a = 8'h00; shifted = 8'h00; direction = 1'b1;
    step();                                     // edge 0: accept
    check_eq("held busy0", 32'(busy), 32'd1);
    step();                                     // edge 1: done
    check_eq("held done1", 32'(done), 32'd1);
    step();                                     // edge 2: DONE -> IDLE, start ignored
    check_eq("held busy2", 32'(busy), 32'd0);
    check_eq("held done2", 32'(done), 32'd0);
    step();                                     // edge 3: IDLE accepts
    start = 1'b0;
    check_eq("held busy3", 32'(busy), 32'd1);
    step();
    check_eq("held done4", 32'(done), 32'd1);
    $display("txn held_start: restart after DONE -> found=%0d amount=%0d", found, shiftamount);
    step();
    step();

    // Asynchronous reset during the search (k=2).
    start = 1'b1; a = 8'hB4; shifted = 8'hA5; direction = 1'b1;
    step();                                     // edge 0
    start = 1'b0;
    step();                                     // edge 1
    step();                                     // edge 2, k=2
    check_eq("rst_mid busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid busy", 32'(busy), 32'd0);
    check_eq("rst_mid done", 32'(done), 32'd0);
    check_eq("rst_mid found", 32'(found), 32'd0);
    check_eq("rst_mid amount", 32'(shiftamount), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_release idle", 32'({busy, done}), 32'd0);
    end
    $display("txn reset_mid: search aborted, block idle");
    run_search("after_reset", 8'hB4, 8'hA5, 1'b1, 1'b1, 3'd3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

  // Absolute time limit to guarantee termination.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rotate_amount_finder.md
Name: rotate_amount_finder

Overview:
- Sequential inverse of the team's combinational N-bit rotator. Given an original word, a rotated word and the rotation direction, it finds the rotate amount that maps one onto the other.
- Searches one rotation position per clock, using a start/busy/done handshake.
- Sits beside the rotator in datapath self-check and alignment-recovery logic.

Parameters:
- N, 8, word width in bits; must be ≥2. The amount field width is $clog2(N).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a search; sampled only in IDLE.
- a  input  N  original (unrotated) word; captured on accepted start.
- shifted  input  N  rotated word to match; captured on accepted start.
- direction  input  1  1 = a was rotated left, 0 = rotated right (same convention as the rotator); captured on accepted start.
- busy  output  1  high while a search is in progress (SEARCH state).
- done  output  1  one-cycle pulse when a result is valid.
- found  output  1  1 = match found; valid from done, held until next accepted start.
- shiftamount  output  $clog2(N)  smallest rotate amount k with rot(a,k,direction)==shifted; 0 when found=0.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time including mid-search):
  - state=IDLE; busy=0, done=0, found=0, shiftamount=0.
  - Internal candidate, target, direction and counter registers are cleared.
  - After release the block waits in IDLE for a new start.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at an edge accepts the request.
  - Captures a into the candidate register, shifted into the target register, direction into its register.
  - counter k=0, found=0, shiftamount=0; next state SEARCH.
  - start=0: stay.
- SEARCH (busy=1), each edge:
  - If candidate==target: shiftamount=k, found=1, next state DONE.
  - Else if k==N-1: found=0, shiftamount=0, next state DONE.
  - Else: rotate the candidate by one bit in the captured direction (left: {c[N-2:0],c[N-1]}; right: {c[0],c[N-1:1]}), k=k+1, stay.
- DONE (busy=0):
  - done=1 for exactly this cycle; next state IDLE unconditionally.
  - start during DONE is ignored.
- Latency, counting the accepting edge as edge 0:
  - Match at amount k: done is high after edge k+1 (k+1 cycles).
  - No match: done is high after edge N.
  - Total occupancy per request is k+2 cycles, or N+1 cycles for no match, before the next start can be accepted.
- start while busy or done is high is ignored; it is not queued.
- Inputs a, shifted and direction may change freely after acceptance; only the captured copies are used.
- Periodic words: the first match in counter order wins, so the reported amount is the smallest.
  - a==shifted always gives amount 0, found=1, with done after 1 cycle.
- found and shiftamount hold their values after done until the next accepted start, which clears both.
- The counter never exceeds N-1; there is no wrap-around.

Test Plan:
- N=8, a=8'hB4, shifted=8'hA5, direction=1, pulse start -> busy for 4 cycles; done pulse after edge 4 with found=1, shiftamount=3; outputs hold afterwards.
- a=8'hB4, shifted=8'h2D, direction=0 -> done after edge 3, found=1, shiftamount=2. The same operands with direction=1 -> found=1, shiftamount=6.
- a=8'h01, shifted=8'h03, direction=1 -> done after edge 8, found=0, shiftamount=0; busy high for exactly 8 cycles.
- Periodic and trivial cases:
  - a=8'h55, shifted=8'hAA, direction=1 -> found=1, shiftamount=1 (smallest).
  - a=shifted=8'h00 -> found=1, shiftamount=0, done after edge 1.
- Start while busy:
  - Start search a=8'h01, shifted=8'h80, direction=1; at edge 3 assert start with different operands -> ignored; result found=1, shiftamount=7.
  - A start held high through DONE is ignored there; if still high in the following IDLE cycle, a new search begins.
- Reset mid-operation: drop rst_n asynchronously during SEARCH (k=2) -> busy, done, found and shiftamount go to 0 immediately, without waiting for a clock edge. After release with start=0 the block stays IDLE; a fresh request then completes normally.
